// File: rtl/alu_pkg.sv
// Shared types for the lab-2 ALU result stage: operation select,
// status-flag bundle and the two-entry output buffer state.
package alu_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_e;

    localparam int ALU_DEFAULT_N = 4;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational result select and N/Z/C/V derivation for the result stage.
// Optional feature macro: ALU_RESULT_OVERFLOW_EN (signed overflow flag V).
// Without it V is forced to 0 and the operand sign bits are not used.
import alu_pkg::*;

module alu_flag_gen #(
    parameter int N = ALU_DEFAULT_N
) (
    input  logic         op,
    input  logic         a_msb,
    input  logic         b_msb,
    input  logic [N-1:0] sum,
    input  logic         cout,
    input  logic [N-1:0] sub,
    input  logic         bout,
    output logic [N-1:0] result,
    output alu_flags_t   flags
);

    logic w_isSub;
    logic w_resMsb;

    assign w_isSub  = (op_e'(op) == OP_SUB);
    assign w_resMsb = result[N-1];

    // Pick the arithmetic result for the requested operation and derive N/Z/C;
    // for subtraction C carries the raw borrow, not an inverted carry.
    always_comb begin
        result  = w_isSub ? sub : sum;
        flags.n = w_resMsb;
        flags.z = (result == '0);
        flags.c = w_isSub ? bout : cout;
        flags.v = 1'b0;
`ifdef ALU_RESULT_OVERFLOW_EN
        if (w_isSub) begin
            flags.v = (a_msb != b_msb) && (w_resMsb != a_msb);
        end else begin
            flags.v = (a_msb == b_msb) && (w_resMsb != a_msb);
        end
`endif
    end

`ifndef ALU_RESULT_OVERFLOW_EN
    logic w_unusedMsbs;
    assign w_unusedMsbs = a_msb ^ b_msb;
`endif

endmodule

// File: rtl/alu_result_stage.sv
// Registered result stage behind the lab-2 adder/subtractor: selects the
// result, computes status flags at capture and holds up to two entries in a
// valid/ready buffer that drains in arrival order.
// Optional feature macro: ALU_RESULT_OVERFLOW_EN (stores the V flag per entry).
import alu_pkg::*;

module alu_result_stage #(
    parameter int N = ALU_DEFAULT_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic         a_msb,
    input  logic         b_msb,
    input  logic [N-1:0] sum,
    input  logic         cout,
    input  logic [N-1:0] sub,
    input  logic         bout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         flag_n,
    output logic         flag_z,
    output logic         flag_c,
    output logic         flag_v
);

`ifdef ALU_RESULT_OVERFLOW_EN
    localparam int FW = 4;
`else
    localparam int FW = 3;
`endif

    buf_state_e r_state;
    buf_state_e w_nextState;

    logic          w_push;
    logic          w_pop;
    logic [N-1:0]  w_newRes;
    alu_flags_t    w_newFlags;
    logic [FW-1:0] w_newFlg;

    // Entry 0 is always the head; entry 1 is only occupied in BUF_TWO.
    logic [N-1:0]  r_res0;
    logic [N-1:0]  r_res1;
    logic [FW-1:0] r_flg0;
    logic [FW-1:0] r_flg1;

    alu_flag_gen #(.N(N)) u_flagGen (
        .op     (op),
        .a_msb  (a_msb),
        .b_msb  (b_msb),
        .sum    (sum),
        .cout   (cout),
        .sub    (sub),
        .bout   (bout),
        .result (w_newRes),
        .flags  (w_newFlags)
    );

`ifdef ALU_RESULT_OVERFLOW_EN
    assign w_newFlg = {w_newFlags.n, w_newFlags.z, w_newFlags.c, w_newFlags.v};
`else
    logic w_unusedV;
    assign w_unusedV = w_newFlags.v;
    assign w_newFlg  = {w_newFlags.n, w_newFlags.z, w_newFlags.c};
`endif

    assign w_push = in_valid && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Buffer occupancy register; reset empties the buffer and drops any push.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= BUF_EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Occupancy transitions from push/pop handshakes.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            BUF_EMPTY: if (w_push) w_nextState = BUF_ONE;
            BUF_ONE: begin
                if (w_push && !w_pop) begin
                    w_nextState = BUF_TWO;
                end else if (!w_push && w_pop) begin
                    w_nextState = BUF_EMPTY;
                end
            end
            BUF_TWO:   if (w_pop) w_nextState = BUF_ONE;
            default:   w_nextState = BUF_EMPTY;
        endcase
    end

    // Handshake outputs decoded purely from the registered state, so out_ready
    // never reaches in_ready combinationally.
    always_comb begin
        in_ready  = (r_state != BUF_TWO);
        out_valid = (r_state != BUF_EMPTY);
    end

    // Entry storage: fill head when empty, fill the second slot behind a
    // stalled head, replace the head on push+pop, shift forward on pop from two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res0 <= '0;
            r_res1 <= '0;
            r_flg0 <= '0;
            r_flg1 <= '0;
        end else begin
            case (r_state)
                BUF_EMPTY: begin
                    if (w_push) begin
                        r_res0 <= w_newRes;
                        r_flg0 <= w_newFlg;
                    end
                end
                BUF_ONE: begin
                    if (w_push && w_pop) begin
                        r_res0 <= w_newRes;
                        r_flg0 <= w_newFlg;
                    end else if (w_push) begin
                        r_res1 <= w_newRes;
                        r_flg1 <= w_newFlg;
                    end
                end
                BUF_TWO: begin
                    if (w_pop) begin
                        r_res0 <= r_res1;
                        r_flg0 <= r_flg1;
                    end
                end
                default: begin
                    r_res0 <= r_res0;
                end
            endcase
        end
    end

    // Present the head entry.
    always_comb begin
        result = r_res0;
        flag_n = r_flg0[FW-1];
        flag_z = r_flg0[FW-2];
        flag_c = r_flg0[FW-3];
`ifdef ALU_RESULT_OVERFLOW_EN
        flag_v = r_flg0[0];
`else
        flag_v = 1'b0;
`endif
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: operands A/B are chosen, the
// adder/subtractor outputs are formed from them, and expected results are
// computed from signed/unsigned arithmetic on A and B.
// Honours ALU_RESULT_OVERFLOW_EN when predicting the V flag.
module tb_alu_result_stage;

    localparam int N = 4;
    localparam int M = 1 << N;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         op;
    logic         a_msb;
    logic         b_msb;
    logic [N-1:0] sum;
    logic         cout;
    logic [N-1:0] sub;
    logic         bout;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] result;
    logic         flag_n;
    logic         flag_z;
    logic         flag_c;
    logic         flag_v;

    typedef struct {
        logic [N-1:0] res;
        logic         n;
        logic         z;
        logic         c;
        logic         v;
    } expT;

    expT q[$];
    int  checks = 0;
    int  errors = 0;

    alu_result_stage #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a_msb     (a_msb),
        .b_msb     (b_msb),
        .sum       (sum),
        .cout      (cout),
        .sub       (sub),
        .bout      (bout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    always #5 clk = ~clk;

    // Expected entry from the arithmetic meaning of A op B.
    function automatic expT modelResult(input bit isSub, input int a, input int b);
        int  sa;
        int  sb;
        int  full;
        int  sres;
        expT e;
        sa = (a >= M / 2) ? a - M : a;
        sb = (b >= M / 2) ? b - M : b;
        if (!isSub) begin
            full = a + b;
            e.c  = (full >= M);
            sres = sa + sb;
        end else begin
            full = a - b;
            e.c  = (a < b);
            sres = sa - sb;
        end
        e.res = N'((full + M) % M);
        e.n   = (int'(e.res) >= M / 2);
        e.z   = (e.res == 0);
`ifdef ALU_RESULT_OVERFLOW_EN
        e.v   = (sres > M / 2 - 1) || (sres < -(M / 2));
`else
        e.v   = 1'b0;
`endif
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "OutValid"}, 8'(out_valid), 8'd0);
        checkOutput({tag, "InReady"},  8'(in_ready),  8'd1);
        checkOutput({tag, "Result"},   8'(result),    8'd0);
        checkOutput({tag, "FlagN"},    8'(flag_n),    8'd0);
        checkOutput({tag, "FlagZ"},    8'(flag_z),    8'd0);
        checkOutput({tag, "FlagC"},    8'(flag_c),    8'd0);
        checkOutput({tag, "FlagV"},    8'(flag_v),    8'd0);
    endtask

    // Offer one cycle of input; records the expected entry if it was taken.
    task automatic applyStimulus(input bit valid, input bit isSub, input int a, input int b, output bit accepted);
        logic [N:0]   wide;
        logic [N-1:0] av;
        logic [N-1:0] bv;
        in_valid = valid;
        if (valid) begin
            av    = N'(a);
            bv    = N'(b);
            wide  = (N + 1)'(a + b);
            op    = isSub;
            sum   = wide[N-1:0];
            cout  = wide[N];
            sub   = N'(a - b);
            bout  = (a < b);
            a_msb = av[N-1];
            b_msb = bv[N-1];
        end else begin
            op    = 1'($urandom_range(0, 1));
            sum   = N'($urandom_range(0, M - 1));
            cout  = 1'($urandom_range(0, 1));
            sub   = N'($urandom_range(0, M - 1));
            bout  = 1'($urandom_range(0, 1));
            a_msb = 1'($urandom_range(0, 1));
            b_msb = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        accepted = valid && in_ready && !rst;
        if (accepted) q.push_back(modelResult(isSub, a, b));
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the presented head against the scoreboard and retires it on pop.
    initial begin
        expT e;
        forever begin
            @(negedge clk);
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedOutput: got result %0h expected no entry at %0t", result, $time);
                end else begin
                    e = q[0];
                    checkOutput("headResult", 8'(result), 8'(e.res));
                    checkOutput("headFlagN",  8'(flag_n), 8'(e.n));
                    checkOutput("headFlagZ",  8'(flag_z), 8'(e.z));
                    checkOutput("headFlagC",  8'(flag_c), 8'(e.c));
                    checkOutput("headFlagV",  8'(flag_v), 8'(e.v));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        int waitCycles;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = 1'b0; sum = '0; cout = 1'b0; sub = '0; bout = 1'b0; a_msb = 1'b0; b_msb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkReset("init");
        rst = 1'b0;

        $display("[TB] directed add/sub cases");
        out_ready = 1'b1;
        applyStimulus(1, 0, 3, 5, acc);  checkOutput("t1Accept", 8'(acc), 8'd1);
        applyStimulus(1, 0, 15, 1, acc); checkOutput("t2Accept", 8'(acc), 8'd1);
        applyStimulus(1, 1, 4, 6, acc);  checkOutput("t3aAccept", 8'(acc), 8'd1);
        applyStimulus(1, 1, 5, 3, acc);  checkOutput("t3bAccept", 8'(acc), 8'd1);
        repeat (2) applyStimulus(0, 0, 0, 0, acc);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(1, 0, 1, 2, acc);  checkOutput("t4FirstAccept", 8'(acc), 8'd1);
        applyStimulus(1, 0, 2, 3, acc);  checkOutput("t4SecondAccept", 8'(acc), 8'd1);
        checkOutput("t4FullInReady", 8'(in_ready), 8'd0);
        applyStimulus(1, 0, 7, 7, acc);  checkOutput("t4ThirdRejected", 8'(acc), 8'd0);
        out_ready = 1'b1;
        applyStimulus(0, 0, 0, 0, acc);
        checkOutput("t4InReadyAfterPop", 8'(in_ready), 8'd1);
        repeat (2) applyStimulus(0, 0, 0, 0, acc);

        $display("[TB] streaming push/pop");
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 1'($urandom_range(0, 1)), $urandom_range(0, M - 1), $urandom_range(0, M - 1), acc);
            checkOutput("t5Accept", 8'(acc), 8'd1);
            checkOutput("t5OutValid", 8'(out_valid), 8'd1);
        end
        applyStimulus(0, 0, 0, 0, acc);

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, M - 1), $urandom_range(0, M - 1), acc);
        end

        $display("[TB] reset while full");
        out_ready = 1'b1;
        waitCycles = 0;
        while (q.size() != 0 && waitCycles < 10) begin
            applyStimulus(0, 0, 0, 0, acc);
            waitCycles++;
        end
        out_ready = 1'b0;
        applyStimulus(1, 1, 9, 2, acc);
        applyStimulus(1, 0, 6, 7, acc);
        checkOutput("t6FullInReady", 8'(in_ready), 8'd0);
        rst = 1'b1;
        applyStimulus(1, 0, 3, 5, acc);
        q.delete();
        rst = 1'b0;
        checkReset("midReset");
        applyStimulus(0, 0, 0, 0, acc);
        checkOutput("t6StillEmpty", 8'(out_valid), 8'd0);
        out_ready = 1'b1;
        applyStimulus(1, 0, 3, 5, acc);  checkOutput("t6ReplayAccept", 8'(acc), 8'd1);
        applyStimulus(0, 0, 0, 0, acc);

        waitCycles = 0;
        while (q.size() != 0 && waitCycles < 10) begin
            applyStimulus(0, 0, 0, 0, acc);
            waitCycles++;
        end
        checkOutput("drainEmpty", 8'(q.size()), 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
